// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter for one RAM port with read-return routing; RAM_ARB_LOCK_EN adds a burst lock input
module ram_port_arbiter #(
    parameter int AW = 11,
    parameter int MW = 8,
    parameter int DW = 8,
    parameter int NR = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NR-1:0]         req,
    input  logic [NR*AW-1:0]      req_addr,
    input  logic [NR*MW*DW-1:0]   req_wdata,
    input  logic [NR*MW-1:0]      req_we,
`ifdef RAM_ARB_LOCK_EN
    input  logic [NR-1:0]         lock,
`endif
    output logic [NR-1:0]         gnt,
    output logic [2:0]            gnt_id,
    output logic [NR-1:0]         rvalid,
    output logic [MW*DW-1:0]      rdata,
    output logic [AW-1:0]         ram_addr,
    output logic [MW*DW-1:0]      ram_d,
    output logic [MW-1:0]         ram_we,
    input  logic [MW*DW-1:0]      ram_q
);
    logic [2:0]    ptr, win;
    logic          hold, found;
    logic [NR-1:0] elig, rot;
    int            sum;
`ifdef RAM_ARB_LOCK_EN
    assign hold = |(lock & req & gnt);
`else
    assign hold = 1'b0;
`endif
    assign elig  = hold ? gnt : req & ~gnt;
    assign rot   = NR'({elig, elig} >> ptr);
    assign rdata = ram_q;
    always_comb begin
        found = 1'b0;
        sum = 0;
        for (int k = 0; k < NR; k++)
            if (!found && rot[k]) begin
                found = 1'b1;
                sum = int'(ptr) + k;
            end
        win = 3'(sum >= NR ? sum - NR : sum);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt      <= '0;
            gnt_id   <= '0;
            rvalid   <= '0;
            ram_addr <= '0;
            ram_d    <= '0;
            ram_we   <= '0;
            ptr      <= '0;
        end else begin
            rvalid <= (ram_we == '0) ? gnt : '0;
            gnt    <= found ? NR'(1) << win : '0;
            ram_we <= found ? req_we[win*MW +: MW] : '0;
            if (found) begin
                gnt_id   <= win;
                ram_addr <= req_addr[win*AW +: AW];
                ram_d    <= req_wdata[win*MW*DW +: MW*DW];
                if (!hold) ptr <= (win == 3'(NR-1)) ? 3'd0 : win + 3'd1;
            end
        end
    end
endmodule
